// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF_RD,
    ARB_MEM_RD,
    ARB_MEM_WR
  } arb_state_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int RAM_ADDR_W = 32;
  localparam int RAM_DATA_W = 8;

  localparam logic [2:0] IF_BYTES = 3'd4;

  // Code 2'b11 is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_asm.sv
// Byte counter, little-endian word assembly buffer and store byte-select mux,
// shared by the read and write paths of mem_arbiter.
module mem_arbiter_byte_asm
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  advance,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [RAM_DATA_W-1:0] din,
  output logic [2:0]            cnt,
  output logic [DATA_WIDTH-1:0] word,
  output logic [RAM_DATA_W-1:0] sel_byte
);

  logic [DATA_WIDTH-1:0] wbuf;
  logic [1:0]            slot;

  // Data seen in cycle c belongs to the address issued in cycle c-1, i.e. byte c-2.
  assign slot     = cnt[1:0] - 2'd2;
  assign sel_byte = wbuf[{cnt[1:0], 3'b000} +: RAM_DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      word <= '0;
      wbuf <= '0;
    end else if (start) begin
      cnt  <= 3'd1;
      word <= '0;
      wbuf <= wdata;
    end else begin
      if (advance) cnt <= cnt + 3'd1;
      if (capture) word[{slot, 3'b000} +: RAM_DATA_W] <= din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM requests onto a single byte-wide RAM port, serialising
// 1/2/4-byte accesses and returning one-cycle done pulses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_inst_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_width_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_done_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic [RAM_DATA_W-1:0] ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [RAM_DATA_W-1:0] ram_din_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1);

  arb_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] prev_a;
  logic [2:0]            n_q;
  logic                  wr_q;
  logic [RAM_DATA_W-1:0] dout_q;
  logic                  if_done_q;
  logic                  mem_done_q;

  logic                  grant_if;
  logic                  grant_mem;
  logic                  rd_state;
  logic                  advance;
  logic                  capture;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [RAM_DATA_W-1:0] sel_byte;

  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (rdy && state == ARB_IDLE && !if_done_q && !mem_done_q) begin
      grant_mem = mem_req_i;
      grant_if  = if_req_i && !mem_req_i;
    end
  end

  assign rd_state = (state == ARB_IF_RD) || (state == ARB_MEM_RD);
  assign advance  = rdy && (state != ARB_IDLE);
  assign capture  = rdy && rd_state && (cnt >= 3'd2);

  mem_arbiter_byte_asm #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_asm (
    .clk      (clk),
    .rst      (rst),
    .start    (grant_if || grant_mem),
    .advance  (advance),
    .capture  (capture),
    .wdata    (mem_wdata_i),
    .din      (ram_din_i),
    .cnt      (cnt),
    .word     (word),
    .sel_byte (sel_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      addr_q     <= '0;
      prev_a     <= '0;
      n_q        <= '0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      prev_a     <= addr_q;
      unique case (state)
        ARB_IDLE: begin
          if (grant_mem) begin
            addr_q <= mem_addr_i;
            prev_a <= mem_addr_i;
            n_q    <= byte_count(mem_width_i);
            if (mem_we_i) begin
              state  <= ARB_MEM_WR;
              wr_q   <= 1'b1;
              dout_q <= mem_wdata_i[RAM_DATA_W-1:0];
            end else begin
              state  <= ARB_MEM_RD;
            end
          end else if (grant_if) begin
            addr_q <= if_addr_i;
            prev_a <= if_addr_i;
            n_q    <= IF_BYTES;
            state  <= ARB_IF_RD;
          end
        end
        ARB_IF_RD, ARB_MEM_RD: begin
          if (state == ARB_IF_RD && flush_i) begin
            state <= ARB_IDLE;
          end else if (cnt == n_q + 3'd1) begin
            state <= ARB_IDLE;
            if (state == ARB_IF_RD) if_done_q  <= 1'b1;
            else                    mem_done_q <= 1'b1;
          end else if (cnt < n_q) begin
            addr_q <= addr_q + ADDR_STEP;
          end
        end
        ARB_MEM_WR: begin
          if (cnt == n_q) begin
            state      <= ARB_IDLE;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            mem_done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_STEP;
            dout_q <= sel_byte;
          end
        end
      endcase
    end
  end

  // While paused mid-read, re-present the address whose byte is still to be
  // captured so ram_din_i carries that byte when rdy returns.
  assign ram_a_o     = (rd_state && !rdy) ? prev_a : addr_q;
  assign ram_wr_o    = wr_q && rdy;
  assign ram_dout_o  = dout_q;
  assign if_done_o   = if_done_q && rdy;
  assign mem_done_o  = mem_done_q && rdy;
  assign if_inst_o   = word;
  assign mem_rdata_o = word;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized accesses against a byte-array model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_width = 2'b00;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_wr;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .flush_i     (flush),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_inst_o   (if_inst),
    .if_done_o   (if_done),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_width_i (mem_width),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .ram_a_o     (ram_a),
    .ram_dout_o  (ram_dout),
    .ram_wr_o    (ram_wr),
    .ram_din_i   (ram_din)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram       [0:4095];
  logic [7:0]  model_mem [0:4095];
  logic        pre_copy = 1'b0;
  logic [39:0] wq [$];
  logic [31:0] a_trace [0:63];
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) begin
    if (pre_copy) for (int i = 0; i < 4096; i++) ram[i] <= model_mem[i];
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  always @(negedge clk) if (ram_wr) wq.push_back({ram_a, ram_dout});

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ak;
    r = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      r = r | (32'(model_mem[ak[11:0]]) << (8 * k));
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] wd, input int n);
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      model_mem[ak[11:0]] = 8'(wd >> (8 * k));
    end
  endfunction

  task automatic check_wr(input string nm, input int ws, input logic [31:0] a,
                          input logic [31:0] wd, input int n);
    logic [31:0] ak;
    check({nm, " write count"}, 64'(wq.size() - ws), 64'(n));
    for (int k = 0; k < n && ws + k < wq.size(); k++) begin
      ak = a + k;
      check({nm, " write"}, 64'(wq[ws + k]), 64'({ak, 8'(wd >> (8 * k))}));
    end
  endtask

  // Called at the start of cycle 0; returns the cycle index of the done pulse.
  task automatic access(input bit is_if, input bit we, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [63:0] stall, input bit rnd,
                        output int lat, output logic [31:0] rd, output int pauses);
    if (is_if) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd;
    end
    lat = -1; rd = '0; pauses = 0;
    for (int c = 0; c < 64; c++) begin
      rdy = !stall[c] && (!rnd || $urandom_range(3) != 0);
      if (rnd && !is_if) flush = 1'($urandom_range(1));
      @(negedge clk);
      a_trace[c] = ram_a;
      if (is_if ? if_done : mem_done) begin
        lat = c;
        rd = is_if ? if_inst : mem_rdata;
        break;
      end
      if (!rdy) pauses++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; rdy = 1'b1; flush = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vt [14];

  initial begin
    int          lat, pauses, ws, n, exp_lat, mem_lat, if_lat, dn;
    logic [31:0] rd, mem_val, if_val, exp_rd, a, wd;
    bit          is_if, we;
    logic [1:0]  w;

    for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
    model_mem['h100] = 8'h13; model_mem['h101] = 8'h05;
    model_mem['h102] = 8'h10; model_mem['h103] = 8'h00;
    model_mem['h104] = 8'h93; model_mem['h105] = 8'h00;
    model_mem['h106] = 8'h20; model_mem['h107] = 8'h00;
    model_mem['h200] = 8'hEF; model_mem['h201] = 8'hBE;
    model_mem['h202] = 8'hAD; model_mem['h203] = 8'hDE;
    model_mem['h500] = 8'h80;
    for (int i = 'h600; i < 'h800; i++) model_mem[i] = 8'($urandom);

    vt[0]  = '{1'b1, 2'b10, 32'h0000_0010, 32'h1122_3344, 32'h0,         5};
    vt[1]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'h1122_3344, 6};
    vt[2]  = '{1'b0, 2'b01, 32'h0000_0012, 32'h0,         32'h0000_1122, 4};
    vt[3]  = '{1'b0, 2'b00, 32'h0000_0013, 32'h0,         32'h0000_0011, 3};
    vt[4]  = '{1'b1, 2'b00, 32'h0000_0020, 32'hAABB_CC77, 32'h0,         2};
    vt[5]  = '{1'b0, 2'b11, 32'h0000_0020, 32'h0,         32'h0000_0077, 6};
    vt[6]  = '{1'b1, 2'b01, 32'h0000_03FF, 32'h1234_ABCD, 32'h0,         3};
    vt[7]  = '{1'b0, 2'b01, 32'h0000_03FF, 32'h0,         32'h0000_ABCD, 4};
    vt[8]  = '{1'b0, 2'b00, 32'h0000_0500, 32'h0,         32'h0000_0080, 3};
    vt[9]  = '{1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 6};
    vt[10] = '{1'b1, 2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         5};
    vt[11] = '{1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 6};
    vt[12] = '{1'b1, 2'b01, 32'h0000_0030, 32'h0000_BEEF, 32'h0,         3};
    vt[13] = '{1'b0, 2'b10, 32'h0000_002E, 32'h0,         32'hBEEF_0000, 6};

    repeat (2) @(posedge clk);
    #1 pre_copy = 1'b1;
    @(posedge clk); #1 pre_copy = 1'b0;
    @(negedge clk);
    check("reset ctl", {if_done, mem_done, ram_wr, ram_dout}, '0);
    check("reset ram_a", ram_a, '0);
    check("reset data", {if_inst, mem_rdata}, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // IF-only word fetch
    ws = wq.size();
    access(1'b1, 1'b0, 2'b10, 32'h100, '0, '0, 1'b0, lat, rd, pauses);
    check("if latency", lat, 6);
    check("if inst", rd, 32'h0010_0513);
    for (int k = 1; k <= 4; k++) check("if ram_a", a_trace[k], 32'h100 + k - 1);
    check_wr("if", ws, '0, '0, 0);

    // Simultaneous requests: MEM first, IF granted after mem done
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b10; mem_addr = 32'h200;
    mem_lat = -1; if_lat = -1; mem_val = '0; if_val = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_done && mem_lat < 0) begin mem_lat = c; mem_val = mem_rdata; end
      if (if_done && if_lat < 0) begin if_lat = c; if_val = if_inst; end
      if (mem_lat >= 0 && if_lat >= 0) break;
      @(posedge clk); #1;
      if (mem_lat >= 0) mem_req = 1'b0;
    end
    @(posedge clk); #1 if_req = 1'b0; mem_req = 1'b0;
    check("both mem latency", mem_lat, 6);
    check("both mem rdata", mem_val, 32'hDEAD_BEEF);
    check("both if latency", if_lat, 13);
    check("both if inst", if_val, 32'h0010_0513);

    // IF read paused in cycles 3-5
    ws = wq.size();
    access(1'b1, 1'b0, 2'b10, 32'h100, '0, 64'h38, 1'b0, lat, rd, pauses);
    check("pause latency", lat, 9);
    check("pause inst", rd, 32'h0010_0513);
    for (int c = 3; c <= 5; c++) check("pause ram_a", a_trace[c], 32'h101);
    check_wr("pause", ws, '0, '0, 0);

    // Flush in cycle 3 redirects fetch; new grant in cycle 4
    if_req = 1'b1; if_addr = 32'h100; lat = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) begin flush = 1'b1; if_addr = 32'h104; end
      if (c == 4) flush = 1'b0;
      @(negedge clk);
      if (if_done) begin lat = c; rd = if_inst; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1 if_req = 1'b0; flush = 1'b0;
    check("flush refetch latency", lat, 10);
    check("flush refetch inst", rd, 32'h0020_0093);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      ws = wq.size();
      n = nbytes(vt[i].w);
      access(1'b0, vt[i].we, vt[i].w, vt[i].a, vt[i].wd, '0, 1'b0, lat, rd, pauses);
      check($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      if (!vt[i].we) check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      check_wr($sformatf("vec%0d", i), ws, vt[i].a, vt[i].wd, vt[i].we ? n : 0);
      if (vt[i].we) model_write(vt[i].a, vt[i].wd, n);
    end

    // Randomized accesses with random pauses and flush noise on MEM
    for (int i = 0; i < 40; i++) begin
      is_if = ($urandom_range(3) == 0);
      we = is_if ? 1'b0 : 1'($urandom_range(1));
      w = is_if ? 2'b10 : 2'($urandom_range(3));
      a = 32'h600 + $urandom_range(0, 511);
      wd = $urandom;
      n = nbytes(w);
      exp_rd = model_read(a, n);
      ws = wq.size();
      access(is_if, we, w, a, wd, '0, 1'b1, lat, rd, pauses);
      exp_lat = (we ? n + 1 : n + 2) + pauses;
      check($sformatf("rnd%0d latency", i), lat, exp_lat);
      if (!we) check($sformatf("rnd%0d rdata", i), rd, exp_rd);
      check_wr($sformatf("rnd%0d", i), ws, a, wd, we ? n : 0);
      if (we) model_write(a, wd, n);
    end

    // Async reset during cycle 2 of a word store
    ws = wq.size();
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10;
    mem_addr = 32'h900; mem_wdata = 32'h5566_7788;
    @(posedge clk);
    @(posedge clk); #3;
    check("store active before reset", ram_wr, 1'b1);
    rst = 1'b0; #1;
    check("reset kills ram_wr", ram_wr, 1'b0);
    check("reset clears ram_a", ram_a, '0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_done || if_done) dn++;
    end
    check("no done after reset", dn, 0);
    check("writes around reset", wq.size() - ws, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into byte transactions and assembles/disassembles 32-bit little-endian words.
- Returns one-cycle done pulses to the requesters.
- Sits between stage_if / stage_mem and the top-level RAM pins; honours the global rdy pause and the ID-stage jump/branch flush.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses (InstAddrBus).
- DATA_WIDTH, 32, width of assembled word (RegBus).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  1 = run, 0 = pause (freeze).
- flush_i  in  1  ID branch/jump taken; cancels an in-flight IF read.
- if_req_i  in  1  fetch request; held until if_done_o.
- if_addr_i  in  32  fetch byte address.
- if_inst_o  out  32  fetched instruction; valid while if_done_o = 1.
- if_done_o  out  1  one-cycle completion pulse.
- mem_req_i  in  1  load/store request; held until mem_done_o.
- mem_we_i  in  1  1 = store.
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  store data; low bytes used.
- mem_rdata_o  out  32  load data, zero-extended; valid while mem_done_o = 1.
- mem_done_o  out  1  one-cycle completion pulse.
- ram_a_o  out  32  RAM byte address.
- ram_dout_o  out  8  byte to RAM.
- ram_wr_o  out  1  1 = write this cycle.
- ram_din_i  in  8  byte from RAM; valid one cycle after its address is driven.

Behaviour:
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Internal byte count n: IF is always 4; MEM uses 1/2/4 from mem_width_i.
- Reset (rst = 0, async): state IDLE, all counters 0, all outputs 0.
- IDLE arbitration:
  - Arbitration happens only when no done pulse is being driven, so a requester that still holds req in its done cycle is not re-granted.
  - Priority: mem_req_i > if_req_i.
  - The request's address, width, we and wdata are latched at grant. Grant cycle = cycle 0.
- Read (IF_RD / MEM_RD):
  - Cycles 1..n drive ram_a_o = A+k, k = 0..n-1.
  - Cycles 2..n+1 capture ram_din_i into byte k-1 of the result: byte 0 goes to bits [7:0], little-endian.
  - The edge closing cycle n+1 returns to IDLE and raises done, so done is high in cycle n+2. A word read therefore has done at cycle 6.
- Write (MEM_WR):
  - Cycles 1..n drive ram_wr_o = 1, ram_a_o = A+k, ram_dout_o = wdata byte k.
  - Done is high in cycle n+1; a word store has done at cycle 5.
- Outputs outside an active phase: ram_wr_o = 0, ram_a_o holds its last value, ram_dout_o = 0.
- Result buffer: rdata/inst are cleared at grant. Unused upper bytes of a byte/half load are 0; sign extension belongs to stage_mem.
- rdy = 0:
  - All state, counters and buffers hold; ram_wr_o is forced 0; done pulses are not emitted and are delayed.
  - During a read, ram_a_o = address of the last issued byte, so ram_din_i is still that byte when rdy returns and capture resumes correctly.
- flush_i:
  - In IF_RD: go to IDLE next edge with no if_done_o; any returning byte is discarded.
  - Flush on the same cycle as the IF done pulse: the pulse is still driven; stage_if ignores it.
  - flush_i has no effect on MEM_RD/MEM_WR.
- Simultaneous requests: MEM is served first. IF waits, is granted on the first eligible IDLE cycle after mem_done_o, and loses no data.
- Address arithmetic: A+k wraps modulo 2^32.
- Reset mid-access: the access is abandoned; no done is issued and no further RAM writes occur.

Decomposition:
- Shared defines.v gains:
  - state encodings (ARB_IDLE, ARB_IF_RD, ARB_MEM_RD, ARB_MEM_WR);
  - width codes (MEM_BYTE, MEM_HALF, MEM_WORD);
  - RamAddrBus / RamDataBus widths.
- Optional sub-module byte_assembler: holds the byte counter, the 32-bit shift/insert buffer and the store byte-select mux. It is shared by the read and write paths.

Test Plan:
- IF only, addr 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a_o = 0x100..0x103 on cycles 1-4; if_inst_o = 0x00100513 with if_done_o high only on cycle 6.
- Same-cycle if_req_i and mem_req_i (word load 0x200 = 0xDEADBEEF) -> mem_done_o on cycle 6 with 0xDEADBEEF, then the IF grant; if_done_o on cycle 13.
- Store half: addr 0x3FF, wdata 0x1234ABCD -> ram_wr_o on cycles 1-2 writing 0xCD@0x3FF, 0xAB@0x400; mem_done_o on cycle 3; no third write.
- Byte load with RAM 0x80 -> mem_rdata_o = 0x00000080, done on cycle 3.
- IF read with rdy low for cycles 3-5 -> no RAM write and no state change while paused; if_done_o on cycle 9 with the correct word.
- flush_i on cycle 3 of an IF read -> IDLE at cycle 4, no if_done_o; a subsequent IF request completes normally. Async reset during a store cycle 2 -> ram_wr_o = 0 immediately.
